// File: rtl/ifft4_pkg.sv
// Shared width, FSM states and complex sample types for the streaming 4-point IFFT.
package ifft4_pkg;

  localparam int W = 33;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CALC1 = 2'd1,
    CALC2 = 2'd2,
    SEND  = 2'd3
  } state_t;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } cplx_w_t;

  typedef struct packed {
    logic [W:0] re;
    logic [W:0] im;
  } cplx_w1_t;

  typedef struct packed {
    logic [W+1:0] re;
    logic [W+1:0] im;
  } cplx_w2_t;

  // Floor division by 4; the 1/4 scaling guarantees the result fits W bits.
  function automatic cplx_w_t div4(input logic [W+1:0] re, input logic [W+1:0] im);
    cplx_w_t r;
    r.re = W'($signed(re) >>> 2);
    r.im = W'($signed(im) >>> 2);
    return r;
  endfunction

endpackage

// File: rtl/ifft4_stream_cbfly.sv
// Combinational complex butterfly: sum and difference of two signed inputs, one bit wider.
module cbfly #(
  parameter int IW = 33
) (
  input  logic [IW-1:0] i_a_re,
  input  logic [IW-1:0] i_a_im,
  input  logic [IW-1:0] i_b_re,
  input  logic [IW-1:0] i_b_im,
  output logic [IW:0]   o_sum_re,
  output logic [IW:0]   o_sum_im,
  output logic [IW:0]   o_dif_re,
  output logic [IW:0]   o_dif_im
);

  assign o_sum_re = {i_a_re[IW-1], i_a_re} + {i_b_re[IW-1], i_b_re};
  assign o_sum_im = {i_a_im[IW-1], i_a_im} + {i_b_im[IW-1], i_b_im};
  assign o_dif_re = {i_a_re[IW-1], i_a_re} - {i_b_re[IW-1], i_b_re};
  assign o_dif_im = {i_a_im[IW-1], i_a_im} - {i_b_im[IW-1], i_b_im};

endmodule

// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse FFT: buffers X0..X3, two registered butterfly stages, sends x0..x3.
// Input and output phases never overlap; a late IN_FIRST restarts the frame at X0.
module ifft4_stream
  import ifft4_pkg::*;
(
  input  logic         CLK,
  input  logic         RST_X,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic         IN_FIRST,
  input  logic [W-1:0] IN_RE,
  input  logic [W-1:0] IN_IM,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] OUT_RE,
  output logic [W-1:0] OUT_IM,
  output logic [1:0]   OUT_IDX,
  output logic         OUT_LAST,
  output logic         RESYNC
);

  state_t     r_state;
  state_t     w_state_nx;
  logic [1:0] r_cnt;
  logic [1:0] r_idx;
  logic       r_in_ready;
  cplx_w_t    r_buf [4];
  cplx_w1_t   r_a, r_b, r_c, r_d;
  cplx_w_t    r_x [4];

  logic       w_in_hs;
  logic       w_out_hs;
  logic       w_resync;
  cplx_w1_t   w_s1_a, w_s1_b, w_s1_c, w_s1_d;
  cplx_w2_t   w_ac_sum, w_ac_dif, w_bd_sum, w_bd_dif;

  assign w_in_hs  = IN_VALID & r_in_ready;
  assign w_out_hs = OUT_VALID & OUT_READY;
  assign w_resync = w_in_hs & IN_FIRST & (r_cnt != 2'd0);

  cbfly #(.IW(W)) u_s1_02 (
    .i_a_re(r_buf[0].re), .i_a_im(r_buf[0].im),
    .i_b_re(r_buf[2].re), .i_b_im(r_buf[2].im),
    .o_sum_re(w_s1_a.re), .o_sum_im(w_s1_a.im),
    .o_dif_re(w_s1_b.re), .o_dif_im(w_s1_b.im)
  );

  cbfly #(.IW(W)) u_s1_13 (
    .i_a_re(r_buf[1].re), .i_a_im(r_buf[1].im),
    .i_b_re(r_buf[3].re), .i_b_im(r_buf[3].im),
    .o_sum_re(w_s1_c.re), .o_sum_im(w_s1_c.im),
    .o_dif_re(w_s1_d.re), .o_dif_im(w_s1_d.im)
  );

  cbfly #(.IW(W+1)) u_s2_ac (
    .i_a_re(r_a.re), .i_a_im(r_a.im),
    .i_b_re(r_c.re), .i_b_im(r_c.im),
    .o_sum_re(w_ac_sum.re), .o_sum_im(w_ac_sum.im),
    .o_dif_re(w_ac_dif.re), .o_dif_im(w_ac_dif.im)
  );

  // D enters with re/im swapped so B+/-jD is picked per component without negating D.
  cbfly #(.IW(W+1)) u_s2_bd (
    .i_a_re(r_b.re), .i_a_im(r_b.im),
    .i_b_re(r_d.im), .i_b_im(r_d.re),
    .o_sum_re(w_bd_sum.re), .o_sum_im(w_bd_sum.im),
    .o_dif_re(w_bd_dif.re), .o_dif_im(w_bd_dif.im)
  );

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      LOAD:    if (w_in_hs && !w_resync && r_cnt == 2'd3) w_state_nx = CALC1;
      CALC1:   w_state_nx = CALC2;
      CALC2:   w_state_nx = SEND;
      SEND:    if (w_out_hs && r_idx == 2'd3) w_state_nx = LOAD;
      default: w_state_nx = LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state    <= LOAD;
      r_cnt      <= 2'd0;
      r_idx      <= 2'd0;
      r_in_ready <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_d        <= '0;
      for (int i = 0; i < 4; i++) begin
        r_buf[i] <= '0;
        r_x[i]   <= '0;
      end
    end else begin
      r_state    <= w_state_nx;
      r_in_ready <= (w_state_nx == LOAD);
      if (w_in_hs) begin
        if (w_resync) begin
          r_buf[0] <= '{re: IN_RE, im: IN_IM};
          r_cnt    <= 2'd1;
        end else begin
          r_buf[r_cnt] <= '{re: IN_RE, im: IN_IM};
          r_cnt        <= r_cnt + 2'd1;
        end
      end
      if (r_state == CALC1) begin
        r_a <= w_s1_a;
        r_b <= w_s1_b;
        r_c <= w_s1_c;
        r_d <= w_s1_d;
      end
      if (r_state == CALC2) begin
        r_x[0] <= div4(w_ac_sum.re, w_ac_sum.im);
        r_x[2] <= div4(w_ac_dif.re, w_ac_dif.im);
        r_x[1] <= div4(w_bd_dif.re, w_bd_sum.im);
        r_x[3] <= div4(w_bd_sum.re, w_bd_dif.im);
      end
      if (r_state == SEND && w_out_hs) r_idx <= r_idx + 2'd1;
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = (r_state == SEND);
  assign OUT_RE    = r_x[r_idx].re;
  assign OUT_IM    = r_x[r_idx].im;
  assign OUT_IDX   = r_idx;
  assign OUT_LAST  = OUT_VALID & (r_idx == 2'd3);
  assign RESYNC    = w_resync;

endmodule
